// File: rtl/cnn_pkg.sv
// Shared types and width helpers for the CNN streaming blocks.
package cnn_pkg;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } unpool_state_e;

  localparam int unsigned CNN_DATA_WIDTH  = 8;
  localparam int unsigned CNN_KERNEL_SIZE = 2;

  // Argmax index width for a K x K window.
  function automatic int unsigned idx_width(input int unsigned k);
    return $clog2(k * k);
  endfunction

  // Counter width able to address n items; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CNN_IDX_WIDTH = idx_width(CNN_KERNEL_SIZE);

  // Pooled value paired with its argmax position, at the default geometry.
  typedef struct packed {
    logic [CNN_DATA_WIDTH-1:0] data;
    logic [CNN_IDX_WIDTH-1:0]  idx;
  } pool_entry_t;

endpackage

// File: rtl/unpool_line_buffer.sv
// One pooled row of {value, argmax} entries: registered write, combinational read.
module unpool_line_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IDX_WIDTH  = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [IDX_WIDTH-1:0]  i_wr_idx,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [IDX_WIDTH-1:0]  o_rd_idx
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [IDX_WIDTH-1:0]  idx;
  } entry_t;

  // Array spans the full address range so every address value is a legal index.
  entry_t r_mem [2**ADDR_WIDTH];

  // Store one entry per accepted pooled pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2**ADDR_WIDTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= '{data: i_wr_data, idx: i_wr_idx};
    end
  end

  // Asynchronous read of the window currently being expanded.
  always_comb begin
    o_rd_data = r_mem[i_rd_addr].data;
    o_rd_idx  = r_mem[i_rd_addr].idx;
  end

endmodule

// File: rtl/max_unpool_stream.sv
// Streaming max-unpool: buffers one pooled row, then expands it into K output rows.
module max_unpool_stream
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_SIZE = 2,
  parameter int unsigned IN_WIDTH    = 4,
  parameter int unsigned IN_HEIGHT   = 4,
  parameter int unsigned IDX_WIDTH   = idx_width(KERNEL_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [IDX_WIDTH-1:0]  s_idx,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_eol,
  output logic                  m_eof
);

  localparam int unsigned OUT_COLS = IN_WIDTH * KERNEL_SIZE;
  localparam int unsigned FILL_W   = cnt_width(IN_WIDTH);
  localparam int unsigned COL_W    = cnt_width(OUT_COLS);
  localparam int unsigned ROW_W    = cnt_width(KERNEL_SIZE);
  localparam int unsigned PROW_W   = cnt_width(IN_HEIGHT);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(IN_WIDTH - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(OUT_COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(KERNEL_SIZE - 1);
  localparam logic [PROW_W-1:0] PROW_LAST = PROW_W'(IN_HEIGHT - 1);

  unpool_state_e         r_state, w_state_nxt;
  logic [FILL_W-1:0]     r_fill_cnt;
  logic [COL_W-1:0]      r_out_col, w_nxt_col;
  logic [ROW_W-1:0]      r_out_row, w_nxt_row;
  logic [PROW_W-1:0]     r_pooled_row;
  logic                  r_s_ready, r_m_valid, r_m_eol, r_m_eof;
  logic [DATA_WIDTH-1:0] r_m_data;

  logic                  w_in_fire, w_out_fire, w_fill_done, w_emit_done, w_load;
  logic [FILL_W-1:0]     w_rd_addr;
  logic [DATA_WIDTH-1:0] w_buf_data, w_rd_data, w_pix;
  logic [IDX_WIDTH-1:0]  w_buf_idx, w_rd_idx;
  logic [31:0]           w_col32, w_pos32;

  unpool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH),
    .DEPTH      (IN_WIDTH),
    .ADDR_WIDTH (FILL_W)
  ) u_line_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_in_fire),
    .i_wr_addr (r_fill_cnt),
    .i_wr_data (s_data),
    .i_wr_idx  (s_idx),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_buf_data),
    .o_rd_idx  (w_buf_idx)
  );

  // Handshake events and FILL/EMIT next-state decision.
  always_comb begin
    w_in_fire   = s_valid && r_s_ready;
    w_out_fire  = r_m_valid && m_ready;
    w_fill_done = w_in_fire && (r_fill_cnt == FILL_LAST);
    w_emit_done = w_out_fire && (r_out_row == ROW_LAST) && (r_out_col == COL_LAST);
    w_load      = w_fill_done || (w_out_fire && !w_emit_done);
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_fill_done) w_state_nxt = EMIT;
      EMIT:    if (w_emit_done) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  // Position of the pixel to load into the output register next.
  always_comb begin
    w_nxt_row = r_out_row;
    w_nxt_col = r_out_col;
    if (r_state == FILL) begin
      w_nxt_row = '0;
      w_nxt_col = '0;
    end else if (r_out_col == COL_LAST) begin
      w_nxt_col = '0;
      w_nxt_row = r_out_row + 1'b1;
    end else begin
      w_nxt_col = r_out_col + 1'b1;
    end
    w_col32   = 32'(w_nxt_col);
    w_rd_addr = FILL_W'(w_col32 / KERNEL_SIZE);
    w_pos32   = 32'(w_nxt_row) * KERNEL_SIZE + (w_col32 % KERNEL_SIZE);
  end

  // Pixel value; the first pixel is loaded on the same edge that writes the last
  // entry, so a write to the addressed entry is forwarded straight through.
  always_comb begin
    w_rd_data = w_buf_data;
    w_rd_idx  = w_buf_idx;
    if (w_in_fire && (r_fill_cnt == w_rd_addr)) begin
      w_rd_data = s_data;
      w_rd_idx  = s_idx;
    end
    w_pix = (32'(w_rd_idx) == w_pos32) ? w_rd_data : '0;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  // Input ready, fill counter and output position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ready    <= 1'b0;
      r_fill_cnt   <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_pooled_row <= '0;
    end else begin
      r_s_ready <= (w_state_nxt == FILL);
      if (w_in_fire) r_fill_cnt <= w_fill_done ? '0 : r_fill_cnt + 1'b1;
      if (w_load) begin
        r_out_row <= w_nxt_row;
        r_out_col <= w_nxt_col;
      end else if (w_emit_done) begin
        r_out_row    <= '0;
        r_out_col    <= '0;
        r_pooled_row <= (r_pooled_row == PROW_LAST) ? '0 : r_pooled_row + 1'b1;
      end
    end
  end

  // Registered output beat; holds while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_eol   <= 1'b0;
      r_m_eof   <= 1'b0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_pix;
      r_m_eol   <= (w_nxt_col == COL_LAST);
      r_m_eof   <= (w_nxt_col == COL_LAST) && (w_nxt_row == ROW_LAST) &&
                   (r_pooled_row == PROW_LAST);
    end else if (w_emit_done) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_eol   <= 1'b0;
      r_m_eof   <= 1'b0;
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_eol   = r_m_eol;
  assign m_eof   = r_m_eof;

endmodule

// File: tb/tb_max_unpool_stream.sv
// Scoreboard bench for max_unpool_stream over three geometries:
// dut 0: K=2 W=2 H=1, dut 1: K=3 W=1 H=1, dut 2: K=2 W=2 H=2.
module tb_max_unpool_stream;

  typedef struct {
    logic [7:0] d;
    logic       eol;
    logic       eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       sv[3];
  logic [7:0] sd[3];
  logic [3:0] si[3];
  logic       sr[3];
  logic       mv[3];
  logic       mr[3];
  logic [7:0] md[3];
  logic       meol[3];
  logic       meof[3];

  exp_t q0[$], q1[$], q2[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   acc[3] = '{0, 0, 0};
  int   pr[3] = '{0, 0, 0};
  int   rmode[3] = '{0, 0, 0};
  int   pat[3] = '{0, 0, 0};

  max_unpool_stream #(.DATA_WIDTH(8), .KERNEL_SIZE(2), .IN_WIDTH(2), .IN_HEIGHT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]),
    .s_idx(si[0][1:0]), .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]),
    .m_eol(meol[0]), .m_eof(meof[0]));

  max_unpool_stream #(.DATA_WIDTH(8), .KERNEL_SIZE(3), .IN_WIDTH(1), .IN_HEIGHT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]),
    .s_idx(si[1]), .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]),
    .m_eol(meol[1]), .m_eof(meof[1]));

  max_unpool_stream #(.DATA_WIDTH(8), .KERNEL_SIZE(2), .IN_WIDTH(2), .IN_HEIGHT(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd[2]),
    .s_idx(si[2][1:0]), .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]),
    .m_eol(meol[2]), .m_eof(meof[2]));

  function automatic int kp(int d); return (d == 1) ? 3 : 2; endfunction
  function automatic int wp(int d); return (d == 1) ? 1 : 2; endfunction
  function automatic int hp(int d); return (d == 2) ? 2 : 1; endfunction

  function automatic int qsize(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void qpush(int d, exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t qfront(int d);
    case (d)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpop(int d);
    case (d)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void check(string nm, int d, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, expv, $time);
    end
  endfunction

  function automatic void fail_now(string nm, int d);
    n_chk++;
    n_fail++;
    $display("FAIL %s dut%0d at %0t", nm, d, $time);
  endfunction

  // Reference: scatter each max into a zeroed K x (W*K) tile, then read it in raster order.
  function automatic void push_row(int d, logic [7:0] vd[2], logic [3:0] vi[2]);
    int k, w, ix;
    logic [7:0] tile[3][6];
    exp_t e;
    k = kp(d);
    w = wp(d);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 6; c++) tile[r][c] = 8'd0;
    for (int p = 0; p < w; p++) begin
      ix = int'(vi[p]);
      if (ix < k * k) tile[ix / k][p * k + ix % k] = vd[p];
    end
    for (int r = 0; r < k; r++)
      for (int c = 0; c < w * k; c++) begin
        e.d   = tile[r][c];
        e.eol = (c == w * k - 1);
        e.eof = e.eol && (r == k - 1) && (pr[d] == hp(d) - 1);
        qpush(d, e);
      end
    pr[d] = (pr[d] + 1) % hp(d);
  endfunction

  // gap >= 0: fixed idle cycles after each pixel; gap < 0: random 0..-gap.
  task automatic send_row(int d, logic [7:0] vd[2], logic [3:0] vi[2], int gap);
    push_row(d, vd, vi);
    for (int p = 0; p < wp(d); p++) begin
      int t;
      t = 0;
      sv[d] = 1'b1;
      sd[d] = vd[p];
      si[d] = vi[p];
      while (!sr[d] && t < 4000) begin
        @(negedge clk);
        t++;
      end
      if (!sr[d]) begin
        fail_now("s_ready_timeout", d);
        sv[d] = 1'b0;
        return;
      end
      if (p == wp(d) - 1) check("no_overlap_mv", d, 32'(mv[d]), 0);
      @(posedge clk);
      #1;
      sv[d] = 1'b0;
      sd[d] = 8'($urandom);
      si[d] = 4'($urandom);
      @(negedge clk);
      if (p == wp(d) - 1) check("first_valid_latency", d, 32'(mv[d]), 1);
      repeat ((gap >= 0) ? gap : $urandom_range(0, -gap)) @(negedge clk);
    end
  endtask

  task automatic drain(int d);
    int t;
    t = 0;
    while (qsize(d) != 0 && t < 5000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("drain_empty", d, qsize(d), 0);
    @(negedge clk);
    check("valid_drop", d, 32'(mv[d]), 0);
  endtask

  task automatic rand_rows(int d, int n);
    logic [7:0] vd[2];
    logic [3:0] vi[2];
    rmode[d] = 1;
    for (int r = 0; r < n; r++) begin
      for (int i = 0; i < 2; i++) begin
        vd[i] = 8'($urandom);
        vi[i] = (d == 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      end
      send_row(d, vd, vi, -2);
    end
    drain(d);
    rmode[d] = 0;
  endtask

  // Monitor: drives m_ready and checks every presented beat against the scoreboard.
  initial begin : monitor
    exp_t e;
    for (int d = 0; d < 3; d++) mr[d] = 1'b1;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        case (rmode[d])
          0:       mr[d] = 1'b1;
          1:       mr[d] = 1'($urandom_range(0, 1));
          default: begin
            mr[d] = (pat[d] % 3 == 0);
            pat[d]++;
          end
        endcase
        if (rst_n === 1'b1 && mv[d] === 1'b1) begin
          check("s_ready_in_emit", d, 32'(sr[d]), 0);
          if (qsize(d) == 0) begin
            fail_now("unexpected_beat", d);
          end else begin
            e = qfront(d);
            check("m_data", d, 32'(md[d]), 32'(e.d));
            check("m_eol", d, 32'(meol[d]), 32'(e.eol));
            check("m_eof", d, 32'(meof[d]), 32'(e.eof));
            if (mr[d]) begin
              qpop(d);
              acc[d]++;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base, t;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      sv[d] = 1'b0;
      sd[d] = 8'd0;
      si[d] = 4'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_s_ready", d, 32'(sr[d]), 0);
      check("rst_m_valid", d, 32'(mv[d]), 0);
      check("rst_m_data", d, 32'(md[d]), 0);
      check("rst_m_eol", d, 32'(meol[d]), 0);
      check("rst_m_eof", d, 32'(meof[d]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check("s_ready_after_reset", d, 32'(sr[d]), 1);

    // Basic expansion, then the same row under a 1,0,0 m_ready pattern.
    send_row(0, '{8'd5, 8'd9}, '{4'd0, 4'd3}, 0);
    drain(0);
    rmode[0] = 2;
    send_row(0, '{8'd5, 8'd9}, '{4'd0, 4'd3}, 0);
    drain(0);
    rmode[0] = 0;

    // Out-of-range argmax clears the whole window.
    send_row(1, '{8'd7, 8'd0}, '{4'd12, 4'd0}, 0);
    drain(1);

    // Two-row frame: end-of-frame only on the final beat.
    send_row(2, '{8'd1, 8'd2}, '{4'd0, 4'd1}, 0);
    send_row(2, '{8'd3, 8'd4}, '{4'd2, 4'd3}, 0);
    drain(2);

    // Input gaps of three cycles between pooled pixels.
    send_row(0, '{8'd5, 8'd9}, '{4'd0, 4'd3}, 3);
    drain(0);

    // Randomised traffic on all three geometries at once.
    fork
      rand_rows(0, 10);
      rand_rows(1, 10);
      rand_rows(2, 8);
    join

    // Reset in the middle of an output block.
    base = acc[0];
    send_row(0, '{8'd5, 8'd9}, '{4'd0, 4'd3}, 0);
    t = 0;
    while (acc[0] < base + 3 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("beats_before_reset", 0, acc[0] - base, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid_drop", 0, 32'(mv[0]), 0);
    check("async_data_clear", 0, 32'(md[0]), 0);
    q0.delete();
    q1.delete();
    q2.delete();
    for (int d = 0; d < 3; d++) pr[d] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_row(0, '{8'd8, 8'd0}, '{4'd1, 4'd0}, 0);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
